multi_read_port_blockram: RTL and testbench

Parametrised successor of the dual-port block RAM. It has one byte-masked write port and NUM_READ_PORT independent registered read ports. A per-set valid bit supports single-set invalidate and a multi-cycle full-flush sequencer. It serves as the storage primitive for cache tag/data arrays that need more than one lookup per cycle plus bulk invalidation.

---
 rtl/multi_read_port_blockram.sv | 111 +++++++++++
 tb/tb_multi_read_port_blockram.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_read_port_blockram.sv
// multi_read_port_blockram: byte-masked single-write, multi-read block RAM with per-set valid bits and a full-flush sequencer
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module multi_read_port_blockram #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS,
  parameter int NUM_READ_PORT = 2,
  parameter CONFIG_MODE = "WriteFirst"
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic                                                write_port_access_en_in,
  input  logic [WRITE_MASK_LEN-1:0]                           write_port_write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    write_port_access_set_addr_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               write_port_data_in,
  input  logic                                                invalidate_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    invalidate_set_addr_in,
  input  logic                                                flush_req_in,
  output logic                                                flush_busy_out,
  output logic                                                flush_done_out,
  input  logic [NUM_READ_PORT-1:0]                            read_port_access_en_in,
  input  logic [NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS-1:0]      read_port_access_set_addr_in,
  output logic [NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_out,
  output logic [NUM_READ_PORT-1:0]                            read_port_valid_out
);
  localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int SW = SET_PTR_WIDTH_IN_BITS;
  localparam int B = `BYTE_LEN_IN_BITS;
  localparam logic [SW:0] SET_LIM = (SW+1)'(NUM_SET);
  localparam bit WRITE_FIRST = CONFIG_MODE == "WriteFirst";

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t state, state_n;
  logic [SW-1:0] ptr;
  logic [W-1:0] mem [NUM_SET];
  logic [NUM_SET-1:0] valid, valid_n;
  logic [W-1:0] merged;
  logic wr, inv;

  function automatic logic in_range(input logic [SW-1:0] a);
    return {1'b0, a} < SET_LIM;
  endfunction

  always_comb begin
    flush_busy_out = state == FLUSH;
    flush_done_out = state == DONE;
    state_n = state == IDLE ? (flush_req_in ? FLUSH : IDLE) :
              state == FLUSH ? (ptr == SW'(NUM_SET - 1) ? DONE : FLUSH) : IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
      ptr <= '0;
    end else begin
      state <= state_n;
      ptr <= flush_busy_out ? ptr + 1'b1 : '0;
    end
  end

  assign wr = write_port_access_en_in && |write_port_write_en_in && !flush_busy_out &&
              in_range(write_port_access_set_addr_in);
  assign inv = invalidate_en_in && !flush_busy_out && in_range(invalidate_set_addr_in);

  always_comb begin
    merged = mem[write_port_access_set_addr_in];
    for (int i = 0; i < WRITE_MASK_LEN; i++)
      if (write_port_write_en_in[i]) merged[i*B +: B] = write_port_data_in[i*B +: B];
  end

  // Invalidate is applied after the write so it wins on a same-set collision.
  always_comb begin
    valid_n = valid;
    if (wr) valid_n[write_port_access_set_addr_in] = 1'b1;
    if (inv) valid_n[invalidate_set_addr_in] = 1'b0;
    if (flush_busy_out) valid_n[ptr] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) valid <= '0;
    else valid <= valid_n;
  end

  always_ff @(posedge clk_in) begin
    if (wr) mem[write_port_access_set_addr_in] <= merged;
  end

  for (genvar p = 0; p < NUM_READ_PORT; p++) begin : g_rd
    logic [SW-1:0] ra;
    logic hit, v_q;
    logic [W-1:0] d_q;
    assign ra = read_port_access_set_addr_in[p*SW +: SW];
    assign hit = WRITE_FIRST && wr && ra == write_port_access_set_addr_in;
    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        d_q <= '0;
        v_q <= 1'b0;
      end else if (read_port_access_en_in[p]) begin
        d_q <= hit ? merged : mem[ra];
        v_q <= !flush_busy_out && in_range(ra) && (WRITE_FIRST ? valid_n[ra] : valid[ra]);
      end
    end
    assign read_port_data_out[p*W +: W] = d_q;
    assign read_port_valid_out[p] = v_q;
  end
endmodule

// File: tb/tb_multi_read_port_blockram.sv
// tb_multi_read_port_blockram: directed checks of write/read/collision/invalidate/flush for both collision policies
module tb_multi_read_port_blockram;
  logic clk_in = 1'b0;
  logic reset_in;
  logic we_en, inv_en, flush_req_in;
  logic [7:0] wen;
  logic [5:0] waddr, iaddr;
  logic [63:0] wdata;
  logic [1:0] ren;
  logic [11:0] raddr;
  logic flush_busy_out, flush_done_out, rf_busy, rf_done;
  logic [127:0] rdata, rf_rdata;
  logic [1:0] rvalid, rf_rvalid;
  int n_vec = 0, n_err = 0;

  always #5 clk_in = ~clk_in;

  multi_read_port_blockram dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .write_port_access_en_in(we_en), .write_port_write_en_in(wen),
    .write_port_access_set_addr_in(waddr), .write_port_data_in(wdata),
    .invalidate_en_in(inv_en), .invalidate_set_addr_in(iaddr),
    .flush_req_in(flush_req_in), .flush_busy_out(flush_busy_out), .flush_done_out(flush_done_out),
    .read_port_access_en_in(ren), .read_port_access_set_addr_in(raddr),
    .read_port_data_out(rdata), .read_port_valid_out(rvalid)
  );

  multi_read_port_blockram #(.CONFIG_MODE("ReadFirst")) dut_rf (
    .clk_in(clk_in), .reset_in(reset_in),
    .write_port_access_en_in(we_en), .write_port_write_en_in(wen),
    .write_port_access_set_addr_in(waddr), .write_port_data_in(wdata),
    .invalidate_en_in(inv_en), .invalidate_set_addr_in(iaddr),
    .flush_req_in(flush_req_in), .flush_busy_out(rf_busy), .flush_done_out(rf_done),
    .read_port_access_en_in(ren), .read_port_access_set_addr_in(raddr),
    .read_port_data_out(rf_rdata), .read_port_valid_out(rf_rvalid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic write_set(input int s, input logic [63:0] d, input logic [7:0] m);
    we_en = 1'b1; wen = m; waddr = s[5:0]; wdata = d;
    tick;
    we_en = 1'b0; wen = '0;
  endtask

  task automatic read0(input int s);
    ren = 2'b01; raddr[5:0] = s[5:0];
    tick;
  endtask

  task automatic run_flush(input bit poke, output int cyc);
    flush_req_in = 1'b1;
    tick;
    flush_req_in = 1'b0;
    cyc = 0;
    while (flush_busy_out && cyc < 200) begin
      cyc++;
      if (poke && cyc == 10) begin
        we_en = 1'b1; wen = '1; waddr = 6'd5; wdata = 64'hdead;
      end
      flush_req_in = poke && cyc == 20;
      tick;
      we_en = 1'b0; wen = '0;
    end
    flush_req_in = 1'b0;
  endtask

  initial begin
    int cyc;
    bit seen;
    reset_in = 1'b1; we_en = 0; inv_en = 0; flush_req_in = 0;
    wen = '0; waddr = '0; iaddr = '0; wdata = '0; ren = '0; raddr = '0;
    repeat (2) tick;
    reset_in = 1'b0;
    check("rst_valid", rvalid, 0);
    check("rst_data0", rdata[63:0], 0);
    check("rst_data1", rdata[127:64], 0);
    check("rst_busy", flush_busy_out, 0);
    check("rst_done", flush_done_out, 0);
    check("rst_rf_valid", rf_rvalid, 0);

    write_set(63, '1, 8'h55);
    read0(63);
    check("masked_data", rdata[63:0] & 64'h00ff00ff00ff00ff, 64'h00ff00ff00ff00ff);
    check("masked_valid", rvalid[0], 1);
    tick;
    check("valid_en_held", rvalid[0], 1);
    ren = 2'b00; raddr[5:0] = 6'd1;
    tick;
    check("hold_valid", rvalid[0], 1);
    check("hold_data", rdata[63:0] & 64'h00ff00ff00ff00ff, 64'h00ff00ff00ff00ff);
    read0(1);
    check("unwritten_valid", rvalid[0], 0);

    we_en = 1; wen = '1; waddr = 6'd1; wdata = rep(8'hf0);
    ren = 2'b11; raddr = {6'd63, 6'd1};
    tick;
    we_en = 0; wen = '0;
    check("wf_coll_data", rdata[63:0], rep(8'hf0));
    check("wf_coll_valid", rvalid[0], 1);
    check("wf_p1_valid", rvalid[1], 1);
    check("wf_p1_data", rdata[127:64] & 64'h00ff00ff00ff00ff, 64'h00ff00ff00ff00ff);
    check("rf_coll_valid", rf_rvalid[0], 0);
    check("rf_p1_valid", rf_rvalid[1], 1);
    we_en = 1; wen = '1; waddr = 6'd1; wdata = rep(8'h0f);
    ren = 2'b01; raddr[5:0] = 6'd1;
    tick;
    we_en = 0; wen = '0;
    check("wf_coll2_data", rdata[63:0], rep(8'h0f));
    check("rf_coll2_data", rf_rdata[63:0], rep(8'hf0));
    check("rf_coll2_valid", rf_rvalid[0], 1);

    for (int i = 0; i < 4; i++) begin
      inv_en = i == 2; iaddr = 6'd2;
      write_set(i, rep(8'h10 + 8'(i)), 8'hff);
      inv_en = 0;
    end
    for (int i = 0; i < 4; i++) begin
      read0(i);
      check($sformatf("inv_wr_valid%0d", i), rvalid[0], i != 2);
      check($sformatf("inv_wr_data%0d", i), rdata[63:0], rep(8'h10 + 8'(i)));
    end
    inv_en = 1; iaddr = 6'd3;
    tick;
    inv_en = 0;
    read0(3);
    check("inv_only_valid", rvalid[0], 0);
    check("inv_only_data", rdata[63:0], rep(8'h13));
    inv_en = 1; iaddr = 6'd0; ren = 2'b01; raddr[5:0] = 6'd0;
    tick;
    inv_en = 0;
    check("wf_inv_coll", rvalid[0], 0);
    check("rf_inv_coll", rf_rvalid[0], 1);

    for (int i = 0; i < 64; i++) write_set(i, rep(8'(i)), 8'hff);
    ren = 2'b10; raddr[11:6] = 6'd63;
    run_flush(1'b1, cyc);
    check("flush_cycles", cyc, 64);
    check("flush_done", flush_done_out, 1);
    check("flush_read_valid", rvalid[1], 0);
    flush_req_in = 1'b1;
    tick;
    flush_req_in = 1'b0;
    check("done_pulse", flush_done_out, 0);
    check("done_req_ignored", flush_busy_out, 0);
    for (int i = 0; i < 64; i++) begin
      read0(i);
      check($sformatf("flushed_valid%0d", i), rvalid[0], 0);
    end
    read0(5);
    check("flush_wr_dropped", rdata[63:0], rep(8'h05));

    for (int i = 0; i < 8; i++) write_set(i, rep(8'h80 + 8'(i)), 8'hff);
    flush_req_in = 1'b1;
    tick;
    flush_req_in = 1'b0;
    repeat (9) tick;
    check("mid_flush_busy", flush_busy_out, 1);
    reset_in = 1'b1;
    tick;
    reset_in = 1'b0;
    check("rst_flush_busy", flush_busy_out, 0);
    seen = flush_done_out;
    for (int i = 0; i < 70; i++) begin
      tick;
      seen |= flush_done_out | flush_busy_out;
    end
    check("rst_no_done", seen, 0);
    for (int i = 0; i < 8; i++) begin
      read0(i);
      check($sformatf("rst_flush_valid%0d", i), rvalid[0], 0);
    end
    write_set(0, rep(8'haa), 8'hff);
    write_set(63, rep(8'hbb), 8'hff);
    run_flush(1'b0, cyc);
    check("reflush_cycles", cyc, 64);
    check("reflush_done", flush_done_out, 1);
    read0(0);
    check("reflush_valid0", rvalid[0], 0);
    read0(63);
    check("reflush_valid63", rvalid[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
